axi4_lite_master: RTL and testbench
===================================

Name: axi4_lite_master

Overview:
- Single-outstanding AXI4 master. It turns a simple CPU-side load/store request into one single-beat AXI4 read or write transaction.
- Instantiated per requester (IFU, LSU) in simple-SoC, in front of the SRAM/crossbar slave.
- Returns one response per request, carrying read data and an error flag.

Parameters:
- AXI_ID, 4'h0, value driven on arid/awid; expected back on rid/bid.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  log2 of byte count: 0, 1 or 2.
- req_wdata  in  32  write data.
- req_wstrb  in  4  write strobes.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  read data, valid with resp_valid.
- resp_err  out  1  set when rresp/bresp != OKAY or the id mismatches.
- AXI4 master channels:
  - aw*: awvalid/awready, awaddr, awid, awlen, awsize, awburst.
  - w*: wvalid/wready, wdata, wstrb, wlast.
  - b*: bvalid/bready, bresp, bid.
  - ar*: arvalid/arready, araddr, arid, arlen, arsize, arburst.
  - r*: rvalid/rready, rdata, rresp, rlast, rid.
  - Widths are standard: len 8, size 3, burst 2, resp 2, id 4.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - In reset: state=IDLE; all valid outputs 0; req_ready=1; bready=rready=0; resp_valid=0; resp_rdata=0; resp_err=0.
- Constant fields: awlen=arlen=0, awburst=arburst=2'b01, wlast=1. awsize and arsize come from req_size.
- States: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/size/wdata/wstrb and drop req_ready.
  - Read: go to RADDR with arvalid=1 next cycle.
  - Write: go to WREQ with awvalid=1 and wvalid=1 next cycle.
- RADDR:
  - Hold arvalid and araddr stable until arready.
  - Then arvalid=0, rready=1, go to RDATA.
- RDATA:
  - On rvalid & rready: capture rdata; set resp_err = (rresp!=0) | (rid!=AXI_ID) | ~rlast.
  - Then pulse resp_valid for 1 cycle, rready=0, return to IDLE.
- WREQ:
  - AW and W handshakes are tracked independently with aw_done/w_done flags.
  - Each valid drops the cycle after its own handshake; either order, or the same cycle, is legal.
  - When both are done, bready=1 and go to WRESP.
  - No valid ever depends on a ready (AXI deadlock rule).
- WRESP:
  - On bvalid & bready: resp_err = (bresp!=0) | (bid!=AXI_ID).
  - Pulse resp_valid, bready=0, return to IDLE.
- Latency:
  - Request accept to arvalid: 1 cycle.
  - Best case for a zero-wait slave: resp_valid 3 cycles after the read accept.
- req_ready is 0 from acceptance until the cycle after resp_valid; no back-to-back overlap.
- A response with no transaction outstanding is ignored; it does not assert resp_valid.
- Reset asserted mid-transaction aborts to IDLE unconditionally; the slave is reset together with the master.

Optional Feature:
- Macro: AXI_MASTER_ALIGN_EN.
- Defined:
  - wdata is shifted left by 8*addr[1:0].
  - wstrb is generated from req_size and addr[1:0]; req_wstrb is ignored.
  - resp_rdata = rdata >> 8*addr[1:0].
  - A misaligned request (addr not a multiple of size) completes with no AXI transaction and resp_err=1, 1 cycle after accept.
- Undefined: wdata, wstrb and rdata pass through unmodified; no misalignment check.

Decomposition:
- Shared package axi4_pkg holds:
  - AXI_BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - The state enum.
  - Size encodings.
- One sub-module: axi_lane_align, the combinational shift/strobe generator used only under AXI_MASTER_ALIGN_EN.

Test Plan:
- Read with zero-wait slave:
  - Stimulus: req addr 0x80000010; slave returns rdata 0xDEADBEEF, rresp 0, rid 0.
  - Response: araddr 0x80000010, arsize 2; resp_valid 3 cycles after accept; resp_rdata 0xDEADBEEF; resp_err 0.
- Write with awready delayed 3 cycles and wready immediate:
  - Response: wvalid drops after 1 cycle, awvalid holds 4 cycles.
  - bready rises only after both handshakes; bresp 0 gives resp_err 0.
- Error responses:
  - Read with rresp=2'b10 gives resp_err 1.
  - Write with bid=4'h3 (AXI_ID 0) gives resp_err 1.
- Back-pressure: arready held 0 for 10 cycles.
  - arvalid and araddr stay stable; req_ready stays 0; no resp_valid.
- Reset mid-transaction: assert rst in RDATA.
  - Next cycle: all valids 0, req_ready 1.
  - A fresh read then completes normally.
- AXI_MASTER_ALIGN_EN:
  - Byte store 0xAB to 0x80000003 gives wdata 0xAB000000, wstrb 4'b1000.
  - Half load at 0x80000001 gives resp_err 1 with no arvalid.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and master FSM states for axi4_lite_master.
package axi4_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4
  } state_t;

endpackage

// File: rtl/axi_lane_align.sv
// Byte-lane shifter and strobe generator for sub-word accesses on a 32-bit bus.
// Only instantiated when AXI_MASTER_ALIGN_EN is defined.
module axi_lane_align
  import axi4_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wstrb,
  output logic [31:0] lane_rdata,
  output logic        misaligned
);

  logic [4:0] shift_s;

  assign shift_s = {addr_lo, 3'b000};

  // Place data on its byte lanes and derive strobes; an unsupported size is treated as misaligned.
  always_comb begin
    lane_wdata = wdata << shift_s;
    lane_rdata = rdata >> shift_s;
    lane_wstrb = 4'b1111;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        lane_wstrb = 4'b0001 << addr_lo;
        misaligned = 1'b0;
      end
      SIZE_HALF: begin
        lane_wstrb = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      SIZE_WORD: begin
        lane_wstrb = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        lane_wstrb = 4'b1111;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4 master: one CPU request becomes one single-beat AXI4 read or write.
// Define AXI_MASTER_ALIGN_EN for byte-lane alignment and misalignment rejection.
module axi4_lite_master
  import axi4_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awid,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  input  logic [3:0]        bid,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid
);

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          size_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [3:0]          wstrb_r;
  logic                arvalid_r;
  logic                awvalid_r;
  logic                wvalid_r;
  logic                aw_done_r;
  logic                w_done_r;
  logic                bready_r;
  logic                rready_r;
  logic                req_ready_r;
  logic                resp_valid_r;
  logic [DATA_W-1:0]   resp_rdata_r;
  logic                resp_err_r;

  logic [DATA_W-1:0]   lane_wdata_s;
  logic [3:0]          lane_wstrb_s;
  logic [DATA_W-1:0]   lane_rdata_s;
  logic                misaligned_s;
  logic                aw_hs_s;
  logic                w_hs_s;

`ifdef AXI_MASTER_ALIGN_EN
  logic [1:0] lane_addr_s;
  logic [1:0] lane_size_s;

  // Lanes follow the incoming request while idle and the latched request once busy.
  always_comb begin
    lane_addr_s = addr_r[1:0];
    lane_size_s = size_r;
    if (state_r == IDLE) begin
      lane_addr_s = req_addr[1:0];
      lane_size_s = req_size;
    end else begin
      lane_addr_s = addr_r[1:0];
      lane_size_s = size_r;
    end
  end

  axi_lane_align u_lane_align (
    .addr_lo    (lane_addr_s),
    .size       (lane_size_s),
    .wdata      (req_wdata),
    .rdata      (rdata),
    .lane_wdata (lane_wdata_s),
    .lane_wstrb (lane_wstrb_s),
    .lane_rdata (lane_rdata_s),
    .misaligned (misaligned_s)
  );
`else
  assign lane_wdata_s = req_wdata;
  assign lane_wstrb_s = req_wstrb;
  assign lane_rdata_s = rdata;
  assign misaligned_s = 1'b0;
`endif

  assign aw_hs_s = awvalid_r & awready;
  assign w_hs_s  = wvalid_r & wready;

  // Transaction FSM; every AXI and response output comes straight from a register here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      size_r       <= 2'b00;
      wdata_r      <= '0;
      wstrb_r      <= 4'b0000;
      arvalid_r    <= 1'b0;
      awvalid_r    <= 1'b0;
      wvalid_r     <= 1'b0;
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      bready_r     <= 1'b0;
      rready_r     <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
    end else begin
      resp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            addr_r      <= req_addr;
            size_r      <= req_size;
            wdata_r     <= lane_wdata_s;
            wstrb_r     <= lane_wstrb_s;
            req_ready_r <= 1'b0;
            if (misaligned_s) begin
              resp_valid_r <= 1'b1;
              resp_rdata_r <= '0;
              resp_err_r   <= 1'b1;
            end else if (req_wen) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
              state_r   <= WREQ;
            end else begin
              arvalid_r <= 1'b1;
              state_r   <= RADDR;
            end
          end else begin
            // Reopens one cycle after the response pulse so requests never overlap it.
            req_ready_r <= 1'b1;
          end
        end
        RADDR: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid) begin
            rready_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= lane_rdata_s;
            resp_err_r   <= (rresp != RESP_OKAY) | (rid != AXI_ID) | ~rlast;
            state_r      <= IDLE;
          end
        end
        WREQ: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if ((aw_done_r | aw_hs_s) && (w_done_r | w_hs_s)) begin
            bready_r <= 1'b1;
            state_r  <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid) begin
            bready_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= '0;
            resp_err_r   <= (bresp != RESP_OKAY) | (bid != AXI_ID);
            state_r      <= IDLE;
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          rready_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  assign awvalid = awvalid_r;
  assign awaddr  = addr_r;
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_r};
  assign awburst = AXI_BURST_INCR;

  assign wvalid = wvalid_r;
  assign wdata  = wdata_r;
  assign wstrb  = wstrb_r;
  assign wlast  = 1'b1;

  assign bready = bready_r;

  assign arvalid = arvalid_r;
  assign araddr  = addr_r;
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_r};
  assign arburst = AXI_BURST_INCR;

  assign rready = rready_r;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: configurable-latency AXI slave plus a transaction-level model.
module tb_axi4_lite_master;

  localparam logic [3:0] AXI_ID = 4'h0;
`ifdef AXI_MASTER_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  axi4_lite_master #(.AXI_ID(AXI_ID), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave behaviour for the next transaction
  int          cfg_ar_d = 0, cfg_r_d = 0, cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  logic [3:0]  cfg_rid = 4'h0, cfg_bid = 4'h0;
  logic        cfg_rlast = 1'b1;
  logic        force_resp = 1'b0;

  // What the slave saw, and protocol monitors
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata, ar_addr0, aw_addr0;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [7:0]  cap_arlen, cap_awlen;
  logic [1:0]  cap_arburst, cap_awburst;
  logic [3:0]  cap_arid, cap_awid, cap_wstrb;
  logic        cap_wlast;
  int ar_hi = 0, aw_hi = 0, w_hi = 0, bready_early = 0, unstable = 0, resp_pulses = 0;
  bit aw_seen = 1'b0, w_seen = 1'b0;

  initial begin
    bit ar_fire, r_fire, aw_fire, w_fire, b_fire, rd_pend, b_pend, aw_got, w_got;
    int ar_wait, aw_wait, w_wait, r_wait, b_wait;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rdata = 32'h0; rresp = 2'b00; rid = 4'h0; rlast = 1'b0; bresp = 2'b00; bid = 4'h0;
    ar_fire = 1'b0; r_fire = 1'b0; aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0;
    rd_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) resp_pulses++;
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_fire = 1'b0; r_fire = 1'b0; aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0;
        rd_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
      end else begin
        // Consequences of the handshakes completed at the last rising edge
        if (ar_fire) begin rd_pend = 1'b1; r_wait = 0; end
        if (r_fire) rd_pend = 1'b0;
        if (aw_fire) begin aw_got = 1'b1; aw_seen = 1'b1; end
        if (w_fire) begin w_got = 1'b1; w_seen = 1'b1; end
        if (b_fire) b_pend = 1'b0;
        if (aw_got && w_got) begin b_pend = 1'b1; b_wait = 0; aw_got = 1'b0; w_got = 1'b0; end
        if (bready && !(aw_seen && w_seen)) bready_early++;

        if (arvalid) begin
          if (ar_hi == 0) ar_addr0 = araddr;
          else if (araddr !== ar_addr0) unstable++;
          ar_hi++;
          arready = (ar_wait >= cfg_ar_d);
          ar_wait++;
        end else begin
          arready = 1'b0; ar_wait = 0;
        end
        if (awvalid) begin
          if (aw_hi == 0) aw_addr0 = awaddr;
          else if (awaddr !== aw_addr0) unstable++;
          aw_hi++;
          awready = (aw_wait >= cfg_aw_d);
          aw_wait++;
        end else begin
          awready = 1'b0; aw_wait = 0;
        end
        if (wvalid) begin
          w_hi++;
          wready = (w_wait >= cfg_w_d);
          w_wait++;
        end else begin
          wready = 1'b0; w_wait = 0;
        end

        if (force_resp) begin
          rvalid = 1'b1; bvalid = 1'b1;
          rdata = cfg_rdata; rresp = cfg_rresp; rid = cfg_rid; rlast = cfg_rlast;
          bresp = cfg_bresp; bid = cfg_bid;
        end else begin
          rvalid = rd_pend && (r_wait >= cfg_r_d);
          rdata = cfg_rdata; rresp = cfg_rresp; rid = cfg_rid; rlast = cfg_rlast;
          if (rd_pend) r_wait++;
          bvalid = b_pend && (b_wait >= cfg_b_d);
          bresp = cfg_bresp; bid = cfg_bid;
          if (b_pend) b_wait++;
        end

        ar_fire = arvalid && arready;
        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
        r_fire  = rvalid && rready;
        b_fire  = bvalid && bready;
        if (ar_fire) begin
          cap_araddr = araddr; cap_arsize = arsize; cap_arlen = arlen;
          cap_arburst = arburst; cap_arid = arid;
        end
        if (aw_fire) begin
          cap_awaddr = awaddr; cap_awsize = awsize; cap_awlen = awlen;
          cap_awburst = awburst; cap_awid = awid;
        end
        if (w_fire) begin
          cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast;
        end
      end
    end
  end

  // Reference model: what the bus and the response should carry for a request
  function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
    int nbytes;
    nbytes = 1 << size;
    return ALIGN_EN && ((addr % nbytes) != 0);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] addr, input logic [31:0] d);
    int lane;
    lane = addr % 4;
    return ALIGN_EN ? (d << (8 * lane)) : d;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [31:0] addr, input logic [1:0] size,
                                             input logic [3:0] s);
    int lane, nbytes;
    logic [3:0] m;
    lane = addr % 4;
    nbytes = 1 << size;
    m = 4'b0000;
    for (int b = 0; b < 4; b++)
      if (b >= lane && b < lane + nbytes) m[b] = 1'b1;
    return ALIGN_EN ? m : s;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] addr, input logic [31:0] d);
    int lane;
    lane = addr % 4;
    return ALIGN_EN ? (d >> (8 * lane)) : d;
  endfunction

  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] rd_o, output logic err_o, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", req_ready, 1'b1);
    ar_hi = 0; aw_hi = 0; w_hi = 0; aw_seen = 1'b0; w_seen = 1'b0;
    bready_early = 0; unstable = 0;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_wdata = wd; req_wstrb = ws;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      if (req_ready) check("req_ready_busy", req_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check("resp_seen", resp_valid, 1'b1);
    check("req_ready_at_resp", req_ready, 1'b0);
    rd_o = resp_rdata;
    err_o = resp_err;
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 1'b0);
    check("req_ready_reopen", req_ready, 1'b1);
  endtask

  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] rd;
    logic err, exp_err;
    int lat, slow;
    do_req(wen, addr, size, wd, ws, rd, err, lat);
    if (model_misaligned(addr, size)) begin
      check("mis_latency", lat, 1);
      check("mis_err", err, 1'b1);
      check("mis_no_axi", ar_hi + aw_hi + w_hi, 0);
    end else if (!wen) begin
      exp_err = (cfg_rresp != 2'b00) || (cfg_rid != AXI_ID) || !cfg_rlast;
      check("rd_latency", lat, 3 + cfg_ar_d + cfg_r_d);
      check("rd_data", rd, model_rdata(addr, cfg_rdata));
      check("rd_err", err, exp_err);
      check("araddr", cap_araddr, addr);
      check("arsize", cap_arsize, {1'b0, size});
      check("arlen_arburst_arid", {cap_arlen, cap_arburst, cap_arid}, {8'd0, 2'b01, AXI_ID});
      check("arvalid_cycles", ar_hi, cfg_ar_d + 1);
      check("ar_stable", unstable, 0);
    end else begin
      exp_err = (cfg_bresp != 2'b00) || (cfg_bid != AXI_ID);
      slow = (cfg_aw_d > cfg_w_d) ? cfg_aw_d : cfg_w_d;
      check("wr_latency", lat, 3 + slow + cfg_b_d);
      check("wr_err", err, exp_err);
      check("awaddr", cap_awaddr, addr);
      check("awsize", cap_awsize, {1'b0, size});
      check("awlen_awburst_awid", {cap_awlen, cap_awburst, cap_awid}, {8'd0, 2'b01, AXI_ID});
      check("wdata", cap_wdata, model_wdata(addr, wd));
      check("wstrb", cap_wstrb, model_wstrb(addr, size, ws));
      check("wlast", cap_wlast, 1'b1);
      check("awvalid_cycles", aw_hi, cfg_aw_d + 1);
      check("wvalid_cycles", w_hi, cfg_w_d + 1);
      check("bready_after_both", bready_early, 0);
      check("aw_stable", unstable, 0);
    end
  endtask

  task automatic set_slave(input int ar_d, input int r_d, input int aw_d, input int w_d,
                           input int b_d);
    cfg_ar_d = ar_d; cfg_r_d = r_d; cfg_aw_d = aw_d; cfg_w_d = w_d; cfg_b_d = b_d;
    cfg_rresp = 2'b00; cfg_bresp = 2'b00; cfg_rid = AXI_ID; cfg_bid = AXI_ID; cfg_rlast = 1'b1;
  endtask

  initial begin
    int n, p0;
    logic [1:0] sz;
    logic [31:0] a;
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_wdata = 32'h0; req_wstrb = 4'h0;
    set_slave(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 5'b00000);
    check("rst_resp", {resp_valid, resp_err}, 2'b00);
    check("rst_rdata", resp_rdata, 32'h0);
    check("const_fields", {awlen, arlen, awburst, arburst, wlast}, {8'd0, 8'd0, 2'b01, 2'b01, 1'b1});
    rst = 1'b0;

    // Zero-wait read
    cfg_rdata = 32'hDEADBEEF;
    run_txn(1'b0, 32'h80000010, 2'd2, 32'h0, 4'h0);
    // Write with awready late by three cycles
    set_slave(0, 0, 3, 0, 0);
    run_txn(1'b1, 32'h80000020, 2'd2, 32'h12345678, 4'hF);
    // Error responses
    set_slave(0, 0, 0, 0, 0);
    cfg_rresp = 2'b10;
    run_txn(1'b0, 32'h80000040, 2'd2, 32'h0, 4'h0);
    set_slave(0, 0, 0, 0, 0);
    cfg_bid = 4'h3;
    run_txn(1'b1, 32'h80000044, 2'd2, 32'hCAFEF00D, 4'hF);
    // Read address back-pressure
    set_slave(10, 0, 0, 0, 0);
    cfg_rdata = 32'h0BADF00D;
    run_txn(1'b0, 32'h80000100, 2'd2, 32'h0, 4'h0);

    // Reset while waiting in the read data phase
    set_slave(0, 6, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000200; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    check("reached_rdata", rready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valids", {arvalid, awvalid, wvalid, bready, rready, resp_valid}, 6'b000000);
    check("midrst_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    set_slave(0, 0, 0, 0, 0);
    cfg_rdata = 32'h5A5A1234;
    run_txn(1'b0, 32'h80000204, 2'd2, 32'h0, 4'h0);

    // Responses with nothing outstanding are ignored
    p0 = resp_pulses;
    force_resp = 1'b1;
    repeat (6) @(negedge clk);
    force_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_resp_ignored", resp_pulses - p0, 0);

`ifdef AXI_MASTER_ALIGN_EN
    set_slave(0, 0, 0, 0, 0);
    run_txn(1'b1, 32'h80000003, 2'd0, 32'h000000AB, 4'hF);
    check("byte_store_wdata", cap_wdata, 32'hAB000000);
    check("byte_store_wstrb", cap_wstrb, 4'b1000);
    run_txn(1'b0, 32'h80000001, 2'd1, 32'h0, 4'h0);
`endif

    // Randomised traffic against the model
    for (int t = 0; t < 40; t++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      cfg_rdata = $urandom;
      if ($urandom_range(0, 3) == 0) cfg_rresp = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) cfg_bresp = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) cfg_rid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) cfg_bid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) cfg_rlast = 1'b0;
      sz = 2'($urandom_range(0, 2));
      a = $urandom;
      run_txn(1'($urandom_range(0, 1)), a, sz, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
